// File: rtl/get_motion_code_dec_if.sv
// get_motion_code_dec_if
//   Bundles the request/result signals of the MPEG-2 motion_code decoder.
//   The master (bitstream flush buffer side) drives the lookahead window and
//   the request. The slave (decoder) returns the motion code, the bit count
//   and the result strobe.
//
//   Signals:
//     in_buf    [10:0]          lookahead window, in_buf[10] is the first bit
//     in_valid                  decode request, level-sensitive
//     outshift  [4:0]           bits consumed (0 = invalid prefix)
//     done                      result valid
//     mcode     [MCODE_W-1:0]   signed motion code, two's complement
//     err                       invalid prefix flag (GET_MOTION_CODE_ERR_EN only)
//
//   Optional feature macro: GET_MOTION_CODE_ERR_EN adds the err signal.
interface get_motion_code_dec_if #(
  parameter int MCODE_W = 5
);
  logic        [10:0]        in_buf;
  logic                      in_valid;
  logic        [4:0]         outshift;
  logic                      done;
  logic signed [MCODE_W-1:0] mcode;
`ifdef GET_MOTION_CODE_ERR_EN
  logic                      err;

  modport master (
    output in_buf, in_valid,
    input  outshift, done, mcode, err
  );

  modport slave (
    input  in_buf, in_valid,
    output outshift, done, mcode, err
  );
`else
  modport master (
    output in_buf, in_valid,
    input  outshift, done, mcode
  );

  modport slave (
    input  in_buf, in_valid,
    output outshift, done, mcode
  );
`endif
endinterface

// File: rtl/get_motion_code_dec.sv
// get_motion_code_dec
//   Registered MPEG-2 motion_code VLC decoder (ISO 13818-2 Table B-10).
//   Decodes the 11-bit lookahead window (MSB first) into a signed motion
//   code and the number of bits consumed (codeword plus sign bit). One
//   cycle of latency; decodes every cycle while in_valid is high.
//
//   Ports:
//     clk   clock
//     rst   asynchronous active-high reset, clears every output register
//     bus   get_motion_code_dec_if.slave
//             in_buf/in_valid in, outshift/done/mcode(/err) out
//
//   Parameter:
//     MCODE_W  width of mcode. 5 wraps +16 onto -16; 6 or more is exact.
//
//   Optional feature macro: GET_MOTION_CODE_ERR_EN
//     Defined: registered err output, 1 for an invalid prefix.
//     Undefined: invalid prefixes show only as outshift = 0.
module get_motion_code_dec #(
  parameter int MCODE_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  get_motion_code_dec_if.slave bus
);

  // Apply the sign bit to the table magnitude and keep the low MCODE_W
  // bits of the two's-complement result (sign-extends for wide MCODE_W).
  function automatic logic [MCODE_W-1:0] apply_sign(input logic [4:0] mag,
                                                     input logic       neg);
    logic signed [6:0] val;
    val = signed'({2'b00, mag});
    if (neg) begin
      val = -val;
    end
    return MCODE_W'(val);
  endfunction

  // Stage p0: combinational decode of the lookahead window
  logic [4:0]         mag_p0;
  logic [4:0]         shift_p0;
  logic               ok_p0;
  logic [3:0]         sidx_p0;
  logic               sgn_p0;
  logic [MCODE_W-1:0] mcode_p0;

  // shift_p0 is the full consumed length including the sign bit, so the
  // sign bit sits at in_buf[11 - shift]. The single-bit code '1' has no
  // sign bit; its magnitude is zero so the sign is irrelevant there.
  always_comb begin
    mag_p0   = 5'd0;
    shift_p0 = 5'd0;
    ok_p0    = 1'b1;
    casez (bus.in_buf)
      11'b1??????????: begin mag_p0 = 5'd0;  shift_p0 = 5'd1;  end
      11'b01?????????: begin mag_p0 = 5'd1;  shift_p0 = 5'd3;  end
      11'b001????????: begin mag_p0 = 5'd2;  shift_p0 = 5'd4;  end
      11'b0001???????: begin mag_p0 = 5'd3;  shift_p0 = 5'd5;  end
      11'b000011?????: begin mag_p0 = 5'd4;  shift_p0 = 5'd7;  end
      11'b0000101????: begin mag_p0 = 5'd5;  shift_p0 = 5'd8;  end
      11'b0000100????: begin mag_p0 = 5'd6;  shift_p0 = 5'd8;  end
      11'b0000011????: begin mag_p0 = 5'd7;  shift_p0 = 5'd8;  end
      11'b000001011??: begin mag_p0 = 5'd8;  shift_p0 = 5'd10; end
      11'b000001010??: begin mag_p0 = 5'd9;  shift_p0 = 5'd10; end
      11'b000001001??: begin mag_p0 = 5'd10; shift_p0 = 5'd10; end
      11'b0000010001?: begin mag_p0 = 5'd11; shift_p0 = 5'd11; end
      11'b0000010000?: begin mag_p0 = 5'd12; shift_p0 = 5'd11; end
      11'b0000001111?: begin mag_p0 = 5'd13; shift_p0 = 5'd11; end
      11'b0000001110?: begin mag_p0 = 5'd14; shift_p0 = 5'd11; end
      11'b0000001101?: begin mag_p0 = 5'd15; shift_p0 = 5'd11; end
      11'b0000001100?: begin mag_p0 = 5'd16; shift_p0 = 5'd11; end
      // 0000 0010 xx and 0000 000x xx: no codeword, flush nothing
      default:         begin ok_p0  = 1'b0; end
    endcase
  end

  // Clamp the sign-bit index so invalid/one-bit codes never index past bit 10.
  always_comb begin
    sidx_p0 = 4'd0;
    if (shift_p0 > 5'd1) begin
      sidx_p0 = 4'(5'd11 - shift_p0);
    end
  end

  assign sgn_p0   = (mag_p0 != 5'd0) ? bus.in_buf[sidx_p0] : 1'b0;
  assign mcode_p0 = apply_sign(mag_p0, sgn_p0);

  // Stage p1: output registers, loaded only on a request
  logic [MCODE_W-1:0] mcode_p1;
  logic [4:0]         shift_p1;
  logic               vld_p1;
`ifdef GET_MOTION_CODE_ERR_EN
  logic               err_p1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcode_p1 <= '0;
      shift_p1 <= 5'd0;
      vld_p1   <= 1'b0;
`ifdef GET_MOTION_CODE_ERR_EN
      err_p1   <= 1'b0;
`endif
    end else begin
      vld_p1 <= bus.in_valid;
      if (bus.in_valid) begin
        mcode_p1 <= mcode_p0;
        shift_p1 <= shift_p0;
`ifdef GET_MOTION_CODE_ERR_EN
        err_p1   <= ~ok_p0;
`endif
      end
    end
  end

  assign bus.mcode    = mcode_p1;
  assign bus.outshift = shift_p1;
  assign bus.done     = vld_p1;
`ifdef GET_MOTION_CODE_ERR_EN
  assign bus.err      = err_p1;
`else
  // ok_p0 only feeds err; without it the decode already maps invalid to 0/0.
  logic unused_ok;
  assign unused_ok = ok_p0;
`endif

endmodule

// File: tb/tb_get_motion_code_dec.sv
// tb_get_motion_code_dec
//   Directed bench for get_motion_code_dec. Two instances share the same
//   stimulus: the default MCODE_W=5 build and an MCODE_W=6 build used for
//   the +/-16 range cases. Expected values are hand-derived from Table B-10.
module tb_get_motion_code_dec;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  get_motion_code_dec_if #(.MCODE_W(5)) bus  ();
  get_motion_code_dec_if #(.MCODE_W(6)) bus6 ();

  assign bus6.in_buf   = bus.in_buf;
  assign bus6.in_valid = bus.in_valid;

  get_motion_code_dec #(.MCODE_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  get_motion_code_dec #(.MCODE_W(6)) dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare the 5-bit instance outputs against hand-computed values.
  task automatic check(input string tag, input int exp_m, input int exp_s,
                       input logic exp_d, input logic exp_e);
    logic [4:0] em;
    logic [4:0] es;
    em = 5'(exp_m);
    es = 5'(exp_s);
    n_tests++;
    assert (bus.done === exp_d) else begin
      n_fail++;
      $error("FAIL %s done got %b exp %b", tag, bus.done, exp_d);
    end
    n_tests++;
    assert (bus.mcode === em) else begin
      n_fail++;
      $error("FAIL %s mcode got %b exp %b", tag, bus.mcode, em);
    end
    n_tests++;
    assert (bus.outshift === es) else begin
      n_fail++;
      $error("FAIL %s outshift got %0d exp %0d", tag, bus.outshift, es);
    end
`ifdef GET_MOTION_CODE_ERR_EN
    n_tests++;
    assert (bus.err === exp_e) else begin
      n_fail++;
      $error("FAIL %s err got %b exp %b", tag, bus.err, exp_e);
    end
`else
    if (exp_e === 1'bx) $display("[TB] note: err expectation undefined for %s", tag);
`endif
  endtask

  task automatic check6(input string tag, input int exp_m, input int exp_s);
    logic [5:0] em;
    logic [4:0] es;
    em = 6'(exp_m);
    es = 5'(exp_s);
    n_tests++;
    assert (bus6.mcode === em) else begin
      n_fail++;
      $error("FAIL %s mcode6 got %b exp %b", tag, bus6.mcode, em);
    end
    n_tests++;
    assert (bus6.outshift === es && bus6.done === 1'b1) else begin
      n_fail++;
      $error("FAIL %s w6 shift/done got %0d/%b exp %0d/1", tag, bus6.outshift, bus6.done, es);
    end
  endtask

  // Apply inputs away from the active edge, then sample 1 time unit after it.
  task automatic step(input logic [10:0] b, input logic v);
    @(negedge clk);
    bus.in_buf   = b;
    bus.in_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst          = 1'b0;
    bus.in_buf   = 11'd0;
    bus.in_valid = 1'b0;

    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1 check("reset_async", 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Single-bit code, single-cycle request, then hold
    step(11'b10110101010, 1'b1);
    check("code_1", 0, 1, 1'b1, 1'b0);
    step(11'b01100000000, 1'b0);
    check("code_1_hold", 0, 1, 1'b0, 1'b0);

    // Small codes, with a hold after a non-zero result
    step(11'b01100000000, 1'b1);
    check("m1", -1, 3, 1'b1, 1'b0);
    step(11'b00010000000, 1'b0);
    check("m1_hold", -1, 3, 1'b0, 1'b0);
    step(11'b00010000000, 1'b1);
    check("p3", 3, 5, 1'b1, 1'b0);

    // Mid/long codes
    step(11'b00001010000, 1'b1);
    check("p5", 5, 8, 1'b1, 1'b0);
    step(11'b00000101100, 1'b1);
    check("p8", 8, 10, 1'b1, 1'b0);
    step(11'b00000011011, 1'b1);
    check("m15", -15, 11, 1'b1, 1'b0);

    // Invalid prefix
    step(11'b00000010000, 1'b1);
    check("invalid_0010", 0, 0, 1'b1, 1'b1);

    // Sustained request: new window every cycle
    step(11'b00110000000, 1'b1); check("m2", -2, 4, 1'b1, 1'b0);
    step(11'b00001100000, 1'b1); check("p4", 4, 7, 1'b1, 1'b0);
    step(11'b00000111000, 1'b1); check("m7", -7, 8, 1'b1, 1'b0);
    step(11'b00001001000, 1'b1); check("m6", -6, 8, 1'b1, 1'b0);
    step(11'b00001011000, 1'b1); check("m5", -5, 8, 1'b1, 1'b0);
    step(11'b00000101011, 1'b1); check("m9", -9, 10, 1'b1, 1'b0);
    step(11'b00000100100, 1'b1); check("p10", 10, 10, 1'b1, 1'b0);
    step(11'b00000100011, 1'b1); check("m11", -11, 11, 1'b1, 1'b0);
    step(11'b00000100000, 1'b1); check("p12", 12, 11, 1'b1, 1'b0);
    step(11'b00000011111, 1'b1); check("m13", -13, 11, 1'b1, 1'b0);
    step(11'b00000011100, 1'b1); check("p14", 14, 11, 1'b1, 1'b0);
    step(11'b00000000111, 1'b1); check("invalid_000", 0, 0, 1'b1, 1'b1);
    step(11'b00011000000, 1'b1); check("m3", -3, 5, 1'b1, 1'b0);
    step(11'b01000000000, 1'b1); check("p1", 1, 3, 1'b1, 1'b0);

    // +/-16: wraps to 5'b10000 at the default width, exact at width 6
    step(11'b00000011000, 1'b1);
    check("p16_w5", 16, 11, 1'b1, 1'b0);
    check6("p16_w6", 16, 11);
    step(11'b00000011001, 1'b1);
    check("m16_w5", -16, 11, 1'b1, 1'b0);
    check6("m16_w6", -16, 11);

    // Reset mid-cycle while a request is pending: outputs clear at once
    // and the request across the reset edge is lost.
    @(negedge clk);
    bus.in_buf   = 11'b01000000000;
    bus.in_valid = 1'b1;
    #1 rst = 1'b1;
    #1 check("reset_mid", 0, 0, 1'b0, 1'b0);
    @(posedge clk);
    #1 check("reset_lost", 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(11'b00100000000, 1'b1);
    check("after_reset_p2", 2, 4, 1'b1, 1'b0);
    step(11'b00100000000, 1'b0);
    check("after_reset_drop", 2, 4, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/get_motion_code_dec.md
Name: get_motion_code_dec

Overview:
- Registered MPEG-2 motion_code VLC decoder (ISO 13818-2 Table B-10).
- Takes an 11-bit lookahead window of the bitstream, MSB first, starting at the first bit of motion_code.
- Returns the signed motion code and the total number of bits consumed, codeword plus sign bit.
- Sits between the bitstream flush buffer and the motion-vector decoder. One instance serves the horizontal component and one the vertical.

Parameters:
- MCODE_W, 5: width of the mcode output. Values of 6 or more carry the full range -16..+16 without wrap.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_buf  in  11  lookahead bits. in_buf[10] is the first bitstream bit.
- in_valid  in  1  decode request, level-sensitive.
- outshift  out  5  bits consumed: 0, 1, or 3..11.
- done  out  1  result valid.
- mcode  out  MCODE_W  signed motion code, two's complement.

Behaviour:
- Reset, asynchronous: mcode=0, outshift=0, done=0.
- Every rising clk edge: done <= in_valid.
- When in_valid=1 at an edge, mcode and outshift are loaded from combinational decode of in_buf. Latency is 1 cycle.
- When in_valid=0 at an edge, mcode and outshift hold their values and done drops to 0.
- If in_valid is held high, the block decodes every cycle and done stays high. The caller may keep in_valid asserted while waiting on done.
- Decode, b = in_buf, s = sign bit immediately after the codeword (s=1 means negative):
  - 1 -> 0, shift 1 (no sign bit).
  - 01s -> 1, shift 3.
  - 001s -> 2, shift 4.
  - 0001s -> 3, shift 5.
  - 0000 11s -> 4, shift 7.
  - 0000 101s -> 5, shift 8.
  - 0000 100s -> 6, shift 8.
  - 0000 011s -> 7, shift 8.
  - 0000 0101 1s -> 8, shift 10.
  - 0000 0101 0s -> 9, shift 10.
  - 0000 0100 1s -> 10, shift 10.
  - 0000 0100 01s -> 11, shift 11.
  - 0000 0100 00s -> 12, shift 11.
  - 0000 0011 11s -> 13, shift 11.
  - 0000 0011 10s -> 14, shift 11.
  - 0000 0011 01s -> 15, shift 11.
  - 0000 0011 00s -> 16, shift 11.
- Any other prefix (0000 0010 xx or 0000 000x xx) is invalid. Result: mcode=0, outshift=0, so no bits are flushed and done still asserts.
- Magnitude/sign split: let v be the magnitude from the table above. mcode = s ? -v : v.
- mcode holds the low MCODE_W bits of that signed result. At MCODE_W=5, +16 yields 5'b10000, which is indistinguishable from -16; this is a known range limit of the default width.
- Bits of in_buf beyond outshift are don't-care.
- rst asserted mid-operation clears all outputs immediately. A request in that cycle is lost.
- No internal state beyond the output registers.

Optional Feature:
- Macro: GET_MOTION_CODE_ERR_EN.
- Defined: adds output port err (1 bit), registered with the other outputs. err=1 for an invalid prefix, otherwise 0. It is loaded only when in_valid=1, held otherwise, and reset to 0.
- Undefined: no err port. Invalid prefixes are signalled only by outshift=0.

Test Plan:
- Reset with rst pulsed asynchronously mid-cycle -> mcode=0, outshift=0, done=0 immediately.
- in_buf=11'b1xxxxxxxxxx, in_valid=1 for 1 cycle -> next cycle done=1, mcode=0, outshift=1. Following cycle done=0 and values hold.
- Small codes:
  - in_buf=11'b01100000000 -> mcode=-1, outshift=3.
  - in_buf=11'b00010000000 -> mcode=+3, outshift=5.
- Mid/long codes:
  - in_buf=11'b00001010000 -> +5, shift 8.
  - in_buf=11'b00000101100 -> +8, shift 10.
  - in_buf=11'b00000011011 -> -15, shift 11.
- Invalid prefix: in_buf=11'b00000010000 -> mcode=0, outshift=0, done=1. With GET_MOTION_CODE_ERR_EN defined, err=1.
- Sustained request: in_valid held high while in_buf changes every cycle -> done stays 1 and each output tracks the previous cycle's in_buf. Then with MCODE_W=6: in_buf=11'b00000011000 -> +16; in_buf=11'b00000011001 -> -16.
